// File: rtl/cmd_tx_sequencer_if.sv
// ============================================================================
// Module   : cmd_tx_sequencer_if
// Brief    : Request/serializer bundle for the SD CMD-line transmit sequencer.
//            The abort pair exists only when CMD_TX_ABORT_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface cmd_tx_sequencer_if #(
  parameter int N = 8
);
  logic          cmd_start;
  logic [5:0]    cmd_index;
  logic [31:0]   cmd_argument;
  logic [N-1:0]  parallel;
  logic          load;
  logic          enable;
  logic          cmd_busy;
  logic          cmd_done;
`ifdef CMD_TX_ABORT_EN
  logic          cmd_abort;
  logic          cmd_aborted;

  modport master (
    output cmd_start, cmd_index, cmd_argument, cmd_abort,
    input  parallel, load, enable, cmd_busy, cmd_done, cmd_aborted
  );
  modport slave (
    input  cmd_start, cmd_index, cmd_argument, cmd_abort,
    output parallel, load, enable, cmd_busy, cmd_done, cmd_aborted
  );
`else
  modport master (
    output cmd_start, cmd_index, cmd_argument,
    input  parallel, load, enable, cmd_busy, cmd_done
  );
  modport slave (
    input  cmd_start, cmd_index, cmd_argument,
    output parallel, load, enable, cmd_busy, cmd_done
  );
`endif
endinterface

`default_nettype wire

// File: rtl/cmd_tx_sequencer.sv
// ============================================================================
// Module   : cmd_tx_sequencer
// Brief    : Builds the 48-bit SD command frame and feeds it to the CMD-line
//            serializer byte by byte, MSB first, with CRC7 and an Ncc gap.
//            Optional abort support: define CMD_TX_ABORT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cmd_tx_sequencer #(
  parameter int N        = 8,
  parameter int IDLE_GAP = 8
) (
  input  logic              sd_clock,
  input  logic              reset,
  cmd_tx_sequencer_if.slave bus
);

  localparam int GW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_DONE  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t         state_q;
  logic [N-1:0]   parallel_q;
  logic           load_q;
  logic           enable_q;
  logic           busy_q;
  logic           done_q;
  logic [31:0]    arg_q;
  logic [7:0]     cur_q;
  logic [6:0]     crc_q;
  logic [2:0]     bit_cnt_q;
  logic [2:0]     byte_cnt_q;
  logic [GW-1:0]  gap_cnt_q;

  logic           bit_d;
  logic [6:0]     crc_d;
  logic [6:0]     crc_ahead_d;
  logic [7:0]     next_byte_d;
  logic           abort_hit;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  // cur_q is the byte the serializer is shifting; 7-bit_cnt == ~bit_cnt.
  assign bit_d       = cur_q[~bit_cnt_q];
  assign crc_d       = crc7_step(crc_q, bit_d);
  // Reload is registered one cycle early, so B5 folds in the byte's last bit too.
  assign crc_ahead_d = crc7_step(crc_d, cur_q[0]);

  always_comb begin
    next_byte_d = {crc_ahead_d, 1'b1};
    case (byte_cnt_q)
      3'd0:    next_byte_d = arg_q[31:24];
      3'd1:    next_byte_d = arg_q[23:16];
      3'd2:    next_byte_d = arg_q[15:8];
      3'd3:    next_byte_d = arg_q[7:0];
      default: next_byte_d = {crc_ahead_d, 1'b1};
    endcase
  end

`ifdef CMD_TX_ABORT_EN
  logic aborted_q;
  assign abort_hit = bus.cmd_abort && ((state_q == S_LOAD) || (state_q == S_SHIFT));
  assign bus.cmd_aborted = aborted_q;
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge sd_clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      parallel_q <= '0;
      load_q     <= 1'b0;
      enable_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      arg_q      <= '0;
      cur_q      <= '0;
      crc_q      <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      gap_cnt_q  <= '0;
`ifdef CMD_TX_ABORT_EN
      aborted_q  <= 1'b0;
`endif
    end else begin
      load_q <= 1'b0;
      done_q <= 1'b0;
`ifdef CMD_TX_ABORT_EN
      aborted_q <= 1'b0;
`endif
      if (load_q) cur_q <= parallel_q;

      if (abort_hit) begin
        enable_q  <= 1'b0;
        gap_cnt_q <= '0;
`ifdef CMD_TX_ABORT_EN
        aborted_q <= 1'b1;
`endif
        if (IDLE_GAP > 0) begin
          state_q <= S_GAP;
        end else begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.cmd_start) begin
              arg_q      <= bus.cmd_argument;
              crc_q      <= '0;
              byte_cnt_q <= '0;
              bit_cnt_q  <= '0;
              parallel_q <= {2'b01, bus.cmd_index};
              load_q     <= 1'b1;
              enable_q   <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= S_LOAD;
            end
          end
          S_LOAD: begin
            bit_cnt_q <= '0;
            state_q   <= S_SHIFT;
          end
          S_SHIFT: begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (byte_cnt_q != 3'd5) crc_q <= crc_d;
            if ((bit_cnt_q == 3'd6) && (byte_cnt_q != 3'd5)) begin
              parallel_q <= next_byte_d;
              load_q     <= 1'b1;
            end
            if (bit_cnt_q == 3'd7) begin
              if (byte_cnt_q == 3'd5) begin
                state_q  <= S_DONE;
                enable_q <= 1'b0;
                done_q   <= 1'b1;
              end else begin
                byte_cnt_q <= byte_cnt_q + 3'd1;
              end
            end
          end
          S_DONE: begin
            gap_cnt_q <= '0;
            if (IDLE_GAP > 0) begin
              state_q <= S_GAP;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
          S_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              gap_cnt_q <= gap_cnt_q + 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.parallel = parallel_q;
  assign bus.load     = load_q;
  assign bus.enable   = enable_q;
  assign bus.cmd_busy = busy_q;
  assign bus.cmd_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_cmd_tx_sequencer.sv
// ============================================================================
// Module   : tb_cmd_tx_sequencer
// Brief    : Directed self-checking bench for cmd_tx_sequencer (default gap
//            instance plus a zero-gap instance); abort checks need CMD_TX_ABORT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cmd_tx_sequencer;

  localparam int GAP = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic [7:0] ser_q;

  cmd_tx_sequencer_if #(.N(8)) bus  ();
  cmd_tx_sequencer_if #(.N(8)) bus0 ();

  cmd_tx_sequencer #(.N(8), .IDLE_GAP(GAP)) dut (
    .sd_clock (clk),
    .reset    (rst),
    .bus      (bus)
  );

  cmd_tx_sequencer #(.N(8), .IDLE_GAP(0)) dut0 (
    .sd_clock (clk),
    .reset    (rst),
    .bus      (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural serializer: captures on load, shifts MSB out while enabled.
  always @(posedge clk) begin
    if (bus.load)        ser_q <= bus.parallel;
    else if (bus.enable) ser_q <= {ser_q[6:0], 1'b0};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_frame(input logic [47:0] exp_frame, input bit poke, input bit hold_next,
                           input logic [5:0] nidx, input logic [31:0] narg);
    logic [7:0]  eb;
    logic [47:0] fr;
    int nload, ndone, nen, idle_c;
    bus.cmd_index    = exp_frame[45:40];
    bus.cmd_argument = exp_frame[39:8];
    bus.cmd_start    = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_start    = 1'b0;
    bus.cmd_index    = ~bus.cmd_index;
    bus.cmd_argument = ~bus.cmd_argument;
    nload = 0; ndone = 0; nen = 0; idle_c = -1; fr = '0;
    for (int c = 1; c <= 51 + GAP; c++) begin
      @(negedge clk);
      if (bus.load) begin
        if (nload < 6) begin
          eb = exp_frame[47 - 8*nload -: 8];
          check("load_cycle", c, 1 + 8*nload);
          check("load_byte", bus.parallel, eb);
        end else begin
          check("extra_load", c, 0);
        end
        nload++;
      end
      if (bus.enable) nen++;
      if (c >= 2 && c <= 49) fr = {fr[46:0], ser_q[7]};
      if (bus.cmd_done) begin
        check("done_cycle", c, 50);
        ndone++;
      end
      if (!bus.cmd_busy && idle_c < 0) idle_c = c;
      if (poke) bus.cmd_start = (c == 10 || c == 55);
      if (hold_next && c >= 57) begin
        bus.cmd_start    = 1'b1;
        bus.cmd_index    = nidx;
        bus.cmd_argument = narg;
      end
    end
    check("load_count", nload, 6);
    check("done_count", ndone, 1);
    check("enable_cycles", nen, 49);
    check("idle_cycle", idle_c, 51 + GAP);
    check("serial_frame", fr, exp_frame);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin : stim
    int cnt;
    int d0, i0, l2;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.cmd_start = 1'b0;  bus.cmd_index = '0;  bus.cmd_argument = '0;
    bus0.cmd_start = 1'b0; bus0.cmd_index = '0; bus0.cmd_argument = '0;
`ifdef CMD_TX_ABORT_EN
    bus.cmd_abort = 1'b0;
    bus0.cmd_abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_parallel", bus.parallel, 8'h00);
    check("rst_load", bus.load, 1'b0);
    check("rst_enable", bus.enable, 1'b0);
    check("rst_busy", bus.cmd_busy, 1'b0);
    check("rst_done", bus.cmd_done, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // CMD0 and CMD8 with hand-computed CRC bytes
    run_frame(48'h40_00000000_95, 1'b0, 1'b0, 6'd0, 32'h0);
    run_frame(48'h48_000001AA_87, 1'b0, 1'b0, 6'd0, 32'h0);

    // CMD17 with ignored strobes while busy, then CMD55 requested during the gap
    run_frame(48'h51_00000000_55, 1'b1, 1'b1, 6'd55, 32'h0);
    run_frame(48'h77_00000000_65, 1'b0, 1'b0, 6'd0, 32'h0);

    // Reset in the middle of a frame
    bus.cmd_index = 6'd8; bus.cmd_argument = 32'h000001AA; bus.cmd_start = 1'b1;
    @(posedge clk);
    #1 bus.cmd_start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_parallel", bus.parallel, 8'h00);
    check("midrst_load", bus.load, 1'b0);
    check("midrst_enable", bus.enable, 1'b0);
    check("midrst_busy", bus.cmd_busy, 1'b0);
    check("midrst_done", bus.cmd_done, 1'b0);
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.cmd_done || bus.load || bus.cmd_busy) cnt++;
    end
    check("midrst_quiet", cnt, 0);
    run_frame(48'h40_00000000_95, 1'b0, 1'b0, 6'd0, 32'h0);

    // Zero-gap instance, strobe held high across the IDLE return
    bus0.cmd_index = 6'd0; bus0.cmd_argument = 32'h0; bus0.cmd_start = 1'b1;
    @(posedge clk);
    #1;
    d0 = -1; i0 = -1; l2 = -1;
    for (int c = 1; c <= 53; c++) begin
      @(negedge clk);
      if (bus0.cmd_done && d0 < 0) d0 = c;
      if (!bus0.cmd_busy && i0 < 0) i0 = c;
      if (bus0.load && c > 41 && l2 < 0) l2 = c;
    end
    bus0.cmd_start = 1'b0;
    check("gap0_done", d0, 50);
    check("gap0_idle", i0, 51);
    check("gap0_reload", l2, 52);

`ifdef CMD_TX_ABORT_EN
    begin : abort_test
      int nd, na, ic;
      bus.cmd_index = 6'd0; bus.cmd_argument = 32'h0; bus.cmd_start = 1'b1;
      @(posedge clk);
      #1 bus.cmd_start = 1'b0;
      nd = 0; na = 0; ic = -1;
      for (int c = 1; c <= 45; c++) begin
        @(negedge clk);
        if (c == 31) begin
          check("abort_enable", bus.enable, 1'b0);
          check("abort_flag", bus.cmd_aborted, 1'b1);
          check("abort_load", bus.load, 1'b0);
          bus.cmd_abort = 1'b0;
        end
        if (bus.cmd_done) nd++;
        if (bus.cmd_aborted) na++;
        if (!bus.cmd_busy && ic < 0) ic = c;
        if (c == 30) bus.cmd_abort = 1'b1;
      end
      check("abort_no_done", nd, 0);
      check("abort_pulse_count", na, 1);
      check("abort_idle", ic, 39);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
